// File: rtl/fpu_sqrt_mantissa_pkg.sv
// Shared definitions for the FPU mantissa square-root datapath.
// Holds the FSM state encoding, the datapath widths and the bit
// positions of the guard/round/sticky triple handed to the rounder.
package fpu_pkg;

    // Datapath widths
    localparam int FPU_MANT_W = 24;              // significand incl. hidden bit
    localparam int FPU_ROOT_W = 26;              // root bits: mantissa + guard + round
    localparam int FPU_RAD_W  = 2 * FPU_ROOT_W;  // radicand, 2 integer bits
    localparam int FPU_REM_W  = FPU_ROOT_W + 2;  // partial remainder

    // Bit positions inside the {G, R, S} triple, matching the rounder's LGRS[2:0]
    localparam int GRS_G = 2;
    localparam int GRS_R = 1;
    localparam int GRS_S = 0;

    // Control FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fpu_sqrt_mantissa_sqrt_step.sv
// One restoring square-root iteration (purely combinational).
// Brings the next radicand pair into the remainder, compares against the
// trial value {root, 01} and subtracts when it fits. The remainder is widened
// by the incoming pair for the compare; the true remainder never exceeds
// 2*root, so truncating the difference back to REM_W bits loses nothing.
module sqrt_step #(
    parameter int ROOT_W = 26,
    parameter int REM_W  = ROOT_W + 2
) (
    input  logic [REM_W-1:0]  i_rem,
    input  logic [1:0]        i_pair,
    input  logic [ROOT_W-1:0] i_root,
    output logic [REM_W-1:0]  o_rem,
    output logic              o_bit
);

    logic [REM_W+1:0] w_shifted;
    logic [REM_W+1:0] w_trial;
    logic [REM_W-1:0] w_diff;

    assign w_shifted = {i_rem, i_pair};
    assign w_trial   = {2'b00, i_root, 2'b01};

    // Trial compare, subtract, and restore when the trial does not fit
    always_comb begin
        o_bit  = (w_shifted >= w_trial);
        w_diff = REM_W'(w_shifted - w_trial);
        o_rem  = o_bit ? w_diff : w_shifted[REM_W-1:0];
    end

endmodule

// File: rtl/fpu_sqrt_mantissa.sv
// Iterative restoring square root of a single-precision significand,
// one root bit per clock. A launch captures the operand, 26 CALC cycles
// build the root, and the DONE cycle presents the truncated 1.23 root with
// its guard/round/sticky bits for the downstream rounder.
//
// Handshake: start_i is a request sampled only in IDLE or DONE (ignored in
// CALC, never queued); valid_o is a one-cycle result pulse with no ready,
// and root_o/grs_o hold their value until the next result. kill_i beats
// start_i in every state and never produces a result.
module fpu_sqrt_mantissa #(
    parameter int MANT_W = 24,
    parameter int ROOT_W = 26
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              kill_i,
    input  logic [MANT_W-1:0] mant_i,
    input  logic              exp_odd_i,
    output logic              busy_o,
    output logic              valid_o,
    output logic [MANT_W-1:0] root_o,
    output logic [2:0]        grs_o,
    output logic [1:0]        dbg_state_o
);

    import fpu_pkg::*;

    localparam int RAD_W = 2 * ROOT_W;
    localparam int REM_W = ROOT_W + 2;
    localparam int CNT_W = $clog2(ROOT_W);

    state_t              r_state;
    logic [RAD_W-1:0]    r_rad;
    logic [REM_W-1:0]    r_rem;
    logic [ROOT_W-1:0]   r_root;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_busy;
    logic                r_valid;
    logic [MANT_W-1:0]   r_root_out;
    logic [2:0]          r_grs;

    logic                w_launch;
    logic [RAD_W-1:0]    w_rad_base;
    logic [RAD_W-1:0]    w_rad_init;
    logic [REM_W-1:0]    w_step_rem;
    logic                w_step_bit;
    logic [ROOT_W-1:0]   w_root_next;

    // Launch is only honoured between operations and never alongside a flush
    assign w_launch    = start_i && !kill_i && (r_state == ST_IDLE || r_state == ST_DONE);

    // Even exponent: value in [1,2) so one leading zero; odd: doubled, value in [2,4)
    assign w_rad_base  = {mant_i, {(RAD_W-MANT_W){1'b0}}};
    assign w_rad_init  = exp_odd_i ? w_rad_base : (w_rad_base >> 1);

    assign w_root_next = {r_root[ROOT_W-2:0], w_step_bit};

    sqrt_step #(
        .ROOT_W (ROOT_W),
        .REM_W  (REM_W)
    ) u_step (
        .i_rem  (r_rem),
        .i_pair (r_rad[RAD_W-1 -: 2]),
        .i_root (r_root),
        .o_rem  (w_step_rem),
        .o_bit  (w_step_bit)
    );

    // Control FSM, iteration registers and registered result outputs
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state    <= ST_IDLE;
            r_rad      <= '0;
            r_rem      <= '0;
            r_root     <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_root_out <= '0;
            r_grs      <= '0;
        end else begin
            r_valid <= 1'b0;
            if (kill_i) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE, ST_DONE: begin
                        if (w_launch) begin
                            r_state <= ST_CALC;
                            r_busy  <= 1'b1;
                            r_rad   <= w_rad_init;
                            r_rem   <= '0;
                            r_root  <= '0;
                            r_cnt   <= CNT_W'(ROOT_W - 1);
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                    ST_CALC: begin
                        r_rad  <= r_rad << 2;
                        r_rem  <= w_step_rem;
                        r_root <= w_root_next;
                        r_cnt  <= r_cnt - 1'b1;
                        if (r_cnt == '0) begin
                            r_state           <= ST_DONE;
                            r_busy            <= 1'b0;
                            r_valid           <= 1'b1;
                            r_root_out        <= w_root_next[ROOT_W-1 -: MANT_W];
                            r_grs[GRS_G]      <= w_root_next[1];
                            r_grs[GRS_R]      <= w_root_next[0];
                            r_grs[GRS_S]      <= |w_step_rem;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy_o      = r_busy;
    assign valid_o     = r_valid;
    assign root_o      = r_root_out;
    assign grs_o       = r_grs;
    assign dbg_state_o = r_state;

endmodule

// File: doc/fpu_sqrt_mantissa.md
# fpu_sqrt_mantissa

Iterative restoring square-root unit for single-precision mantissas, one root bit per clock. It sits directly upstream of the sqrt rounding stage. It takes the 24-bit significand (hidden bit included) and the exponent-parity flag from the FPU sqrt front end. It produces the 24-bit truncated root and the guard/round/sticky triple that the rounder consumes on its `LGRS[2:0]` input.

## Interface

Parameters:
- `MANT_W`, 24: significand width including hidden bit.
- `ROOT_W`, 26: root bits computed, MANT_W + guard + round.

Ports:
- `clk_i` in 1: clock; all state on rising edge.
- `reset_i` in 1: reset; asynchronous, active-low.
- `start_i` in 1: launch request; sampled only in IDLE or DONE.
- `kill_i` in 1: flush; aborts any operation and returns to IDLE.
- `mant_i` in MANT_W: significand, format 1.23 (`mant_i[23]` = 1 for normals).
- `exp_odd_i` in 1: unbiased exponent is odd; radicand doubled.
- `busy_o` out 1: high in CALC.
- `valid_o` out 1: one-cycle pulse in DONE.
- `root_o` out MANT_W: truncated root, format 1.23.
- `grs_o` out 3: {G, R, S}; drives the rounder's `LGRS[2:0]`.

## Operation

FSM states: IDLE, CALC, DONE.

Launch:
- Accepted on a clock edge with `start_i`=1 while in IDLE or DONE, and `kill_i`=0.
- Operands are captured on that edge, the counter is set to ROOT_W-1, and the state moves to CALC.

Radicand (52 bits, 2 integer bits):
- `exp_odd_i`=0: {1'b0, `mant_i`, 27'b0}, value in [1,2).
- `exp_odd_i`=1: {`mant_i`, 28'b0}, value in [2,4).

CALC iteration (restoring):
- Remainder (28 bits) is shifted left 2 and the next two radicand bits are brought in.
- Trial value = {root, 2'b01}.
- If remainder ≥ trial: subtract trial and shift 1 into the root. Otherwise keep the remainder and shift 0 into the root.
- The counter decrements each cycle. When it reaches 0, the state moves to DONE.

DONE:
- `root_o` = root[25:2].
- `grs_o` = {root[1], root[0], |remainder}.
- `valid_o` = 1 for exactly this cycle.
- Next state is IDLE, or CALC if a new launch is accepted.

Hold and control rules:
- `root_o` and `grs_o` hold their last result until the next DONE.
- `start_i` during CALC is ignored. No queueing.
- `kill_i` has priority over `start_i` in every state. It forces IDLE on the next edge, suppresses `valid_o`, and leaves `root_o`/`grs_o` unchanged.
- `mant_i[23]`=0 (subnormal) is out of scope; the front end normalises first. Results for such inputs are undefined but must not hang the FSM.

## Timing

- Reset (`reset_i`=0, asynchronous):
  - State IDLE.
  - `busy_o`=0, `valid_o`=0.
  - `root_o`=0, `grs_o`=0.
  - Counter and remainder cleared.
- Reset mid-CALC drops the operation with no `valid_o`.
- Latency: launch on edge E0, CALC during cycles 1..26, `valid_o` high during cycle 27 (27 cycles start-to-result).
- Throughput: a new launch is accepted in the DONE cycle, so back-to-back operations run every 27 cycles.
- `busy_o` = (state == CALC), registered. It is never high together with `valid_o`.
- Outputs are registered; there is no combinational path from `mant_i`/`start_i` to any output.

## Structure

Shared package `fpu_pkg`:
- State encoding (2-bit localparams IDLE=0, CALC=1, DONE=2).
- `MANT_W`, `ROOT_W`, radicand width 52 and remainder width 28.
- Constants shared with the rounder's GRS bit ordering.

Sub-module:
- One natural sub-module, `sqrt_step`: combinational trial subtract/compare, taking remainder, next radicand pair and partial root, and returning the new remainder and root bit.
- The FSM, counter and shift registers remain in the top.

## Test plan

- Reset during CALC, then release: all outputs 0, state IDLE, no `valid_o`. A following launch with `mant_i`=0x800000, `exp_odd_i`=0 gives `root_o`=0x800000, `grs_o`=3'b000, `valid_o` exactly in cycle 27.
- `mant_i`=0x800000, `exp_odd_i`=1 (√2) -> `root_o`=0xB504F3, `grs_o`=3'b001.
- `mant_i`=0xC00000, `exp_odd_i`=1 (√3) -> `root_o`=0xDDB3D7, `grs_o`=3'b011.
- `mant_i`=0x900000, `exp_odd_i`=1 (√2.25) -> `root_o`=0xC00000, `grs_o`=3'b000.
- `start_i` re-asserted in cycle 10 of an operation:
  - Expected: ignored, and the first result is unchanged.
  - Then `start_i` held high in DONE: second launch accepted, second `valid_o` in cycle 54.
- `kill_i` pulsed in cycle 15:
  - Expected: IDLE next cycle, no `valid_o`, and `root_o`/`grs_o` retain the previous result.
  - `kill_i` together with `start_i` in IDLE: no launch.
